// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner.
// Key index convention: row*NUM_COLS + col.
package keypad_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;
    localparam int KEY_W    = NUM_ROWS * NUM_COLS;

    typedef enum logic [1:0] {
        IDLE,
        PRESSED,
        LOCKED
    } kp_state_t;

    function automatic logic is_onehot(input logic [KEY_W-1:0] v);
        return (v != '0) && ((v & (v - KEY_W'(1))) == '0);
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for asynchronous inputs; 2-cycle latency, no backpressure.
// Reset loads RST_VAL into both stages so no spurious edge appears after reset.
module sync2 #(
    parameter int               WIDTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: column scan, frame debounce, n-key-lockout FSM.
// Outputs update the cycle after the frame-end edge of the accepting frame.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic        Clk,
    input  logic        Rst_n,
    output logic [3:0]  col_n,
    input  logic [3:0]  row_n,
    output logic [15:0] numericKey,
    output logic        keyValid,
    output logic        keyStrobe,
    output logic        multiKey
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);

    logic [DIV_W-1:0]    div_q, div_d;
    logic [1:0]          col_q, col_d;
    logic [KEY_W-1:0]    asm_q, asm_d, frame_d;
    logic [KEY_W-1:0]    prev_q, prev_d;
    logic [KEY_W-1:0]    deb_q, deb_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    kp_state_t           state_q, state_d;
    logic [KEY_W-1:0]    key_q, key_d;
    logic                strobe_q, strobe_d;
    logic                valid_q, multi_q;
    logic [NUM_ROWS-1:0] row_sync;
    logic                last_dwell, frame_end;

    // Idle rows read high, so the synchroniser resets to "no key".
    sync2 #(.WIDTH(NUM_ROWS), .RST_VAL('1)) u_row_sync (
        .clk_i  (Clk),
        .rst_ni (Rst_n),
        .d_i    (row_n),
        .q_o    (row_sync)
    );

    assign last_dwell = (div_q == DIV_W'(SCAN_DIV - 1));
    assign frame_end  = last_dwell && (col_q == 2'd3);
    assign col_n      = ~(4'b0001 << col_q);

    always_comb begin
        div_d = last_dwell ? '0 : div_q + DIV_W'(1);
        col_d = last_dwell ? col_q + 2'd1 : col_q;

        // frame_d is the complete frame when evaluated on column 3's last dwell cycle.
        frame_d = asm_q;
        for (int r = 0; r < NUM_ROWS; r++) begin
            frame_d[r*NUM_COLS + int'(col_q)] = ~row_sync[r];
        end
        asm_d = last_dwell ? frame_d : asm_q;

        prev_d = prev_q;
        cnt_d  = cnt_q;
        deb_d  = deb_q;
        if (frame_end) begin
            if (frame_d != prev_q) begin
                prev_d = frame_d;
                cnt_d  = CNT_W'(1);
            end else if (cnt_q != CNT_W'(DEBOUNCE_SCANS)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            if (cnt_d == CNT_W'(DEBOUNCE_SCANS)) begin
                deb_d = frame_d;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        key_d    = key_q;
        strobe_d = 1'b0;
        if (frame_end) begin
            unique case (state_q)
                IDLE: begin
                    if (is_onehot(deb_d)) begin
                        state_d  = PRESSED;
                        key_d    = deb_d;
                        strobe_d = 1'b1;
                    end else if (deb_d != '0) begin
                        state_d = LOCKED;
                    end
                end
                PRESSED: begin
                    if (deb_d == '0) begin
                        state_d = IDLE;
                        key_d   = '0;
                    end else if (deb_d != key_q) begin
                        state_d = LOCKED;
                        key_d   = '0;
                    end
                end
                LOCKED: begin
                    if (deb_d == '0) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    key_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            div_q    <= '0;
            col_q    <= '0;
            asm_q    <= '0;
            prev_q   <= '0;
            deb_q    <= '0;
            cnt_q    <= '0;
            state_q  <= IDLE;
            key_q    <= '0;
            strobe_q <= 1'b0;
            valid_q  <= 1'b0;
            multi_q  <= 1'b0;
        end else begin
            div_q    <= div_d;
            col_q    <= col_d;
            asm_q    <= asm_d;
            prev_q   <= prev_d;
            deb_q    <= deb_d;
            cnt_q    <= cnt_d;
            state_q  <= state_d;
            key_q    <= key_d;
            strobe_q <= strobe_d;
            valid_q  <= (state_d == PRESSED);
            multi_q  <= (state_d == LOCKED);
        end
    end

    assign numericKey = key_q;
    assign keyValid   = valid_q;
    assign keyStrobe  = strobe_q;
    assign multiKey   = multi_q;

endmodule
